// File: rtl/data_cache_pkg.sv
// Shared constants, FSM state encoding and line/word helper for the data_cache slice.
package data_cache_pkg;

    localparam int ADDR_W         = 15;
    localparam int WORD_W         = 32;
    localparam int LINE_W         = 128;
    localparam int WORDS_PER_LINE = 4;
    localparam int OFF_W          = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FILL   = 2'd2
    } state_t;

    // Word k of a line sits in the most significant slot for k=0, descending.
    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input logic [OFF_W-1:0]  k);
        logic [LINE_W-1:0] shifted;
        shifted = line << (WORD_W * int'(k));
        return shifted[LINE_W-1 -: WORD_W];
    endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU load-path and line-memory signals of data_cache, with master (CPU/memory side)
// and slave (cache side) modports.
interface data_cache_if;
    import data_cache_pkg::*;

    // Request handshake: a request transfers on a rising edge where cpu_req && cpu_ready;
    // cpu_req/cpu_addr are ignored while cpu_ready is low. resp_valid is a one-cycle pulse
    // qualifying cpu_rdata/resp_hit and carries no back-pressure.
    logic                 cpu_req;
    logic [ADDR_W-1:0]    cpu_addr;
    logic                 cpu_ready;
    logic                 resp_valid;
    logic [WORD_W-1:0]    cpu_rdata;
    logic                 resp_hit;
    logic [ADDR_W-1:0]    mem_addr;
    logic [LINE_W-1:0]    mem_line;
    state_t               dbg_state;

    modport master (
        output cpu_req, cpu_addr, mem_line,
        input  cpu_ready, resp_valid, cpu_rdata, resp_hit, mem_addr, dbg_state
    );

    modport slave (
        input  cpu_req, cpu_addr, mem_line,
        output cpu_ready, resp_valid, cpu_rdata, resp_hit, mem_addr, dbg_state
    );

endinterface

// File: rtl/data_cache_array.sv
// Tag/valid/data storage for data_cache: combinational read, single write port,
// valid bits cleared by the synchronous active-low reset.
module data_cache_array
    import data_cache_pkg::*;
#(
    parameter  int LINES = 256,
    localparam int IDX_W = $clog2(LINES),
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_line
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINE_W-1:0] data_mem [LINES];

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data contents are meaningless until the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en && rst) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_line;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_line  = data_mem[rd_idx];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped read-only data cache: IDLE/LOOKUP/FILL controller over data_cache_array.
// Optional saturating hit/miss counters are built when DATA_CACHE_STATS_EN is defined.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int LINES        = 256,
    parameter int MISS_PENALTY = 4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef DATA_CACHE_STATS_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    data_cache_if.slave bus
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam int CNT_W = (MISS_PENALTY > 1) ? $clog2(MISS_PENALTY) : 1;

    state_t              state;
    state_t              state_nx;
    logic [ADDR_W-1:0]   req_addr;
    logic                miss_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                resp_valid_q;
    logic                resp_hit_q;
    logic [WORD_W-1:0]   rdata_q;

    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [OFF_W-1:0]    req_off;
    logic                arr_valid;
    logic [TAG_W-1:0]    arr_tag;
    logic [LINE_W-1:0]   arr_line;
    logic                hit;
    logic                fill_done;
    logic                wr_en;

    assign req_off   = req_addr[OFF_W-1:0];
    assign req_idx   = req_addr[IDX_W+OFF_W-1:OFF_W];
    assign req_tag   = req_addr[ADDR_W-1:IDX_W+OFF_W];
    assign hit       = arr_valid && (arr_tag == req_tag);
    assign fill_done = (state == FILL) && (cnt_q == '0);

    data_cache_array #(.LINES(LINES)) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (req_idx),
        .rd_valid (arr_valid),
        .rd_tag   (arr_tag),
        .rd_line  (arr_line),
        .wr_en    (wr_en),
        .wr_idx   (req_idx),
        .wr_tag   (req_tag),
        .wr_line  (bus.mem_line)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.cpu_req) state_nx = LOOKUP;
            LOOKUP:  state_nx = hit ? IDLE : FILL;
            FILL:    if (fill_done) state_nx = LOOKUP;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.cpu_ready = 1'b0;
        bus.mem_addr  = '0;
        wr_en         = 1'b0;
        case (state)
            IDLE: bus.cpu_ready = 1'b1;
            FILL: begin
                bus.mem_addr = {req_tag, req_idx, {OFF_W{1'b0}}};
                wr_en        = fill_done;
            end
            default: ;
        endcase
    end

    // miss_q remembers that this request already went through a fill, so the
    // post-fill lookup reports resp_hit=0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_addr     <= '0;
            miss_q       <= 1'b0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            rdata_q      <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        req_addr <= bus.cpu_addr;
                        miss_q   <= 1'b0;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        rdata_q      <= line_word(arr_line, req_off);
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= !miss_q;
                    end else begin
                        miss_q <= 1'b1;
                        cnt_q  <= CNT_W'(MISS_PENALTY - 1);
                    end
                end
                FILL: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_hit   = resp_hit_q;
    assign bus.cpu_rdata  = rdata_q;
    assign bus.dbg_state  = state;

`ifdef DATA_CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP) begin
            if (hit && !miss_q && (hit_count != '1)) hit_count <= hit_count + 1'b1;
            if (!hit && (miss_count != '1)) miss_count <= miss_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus random reads checked
// against an abstract direct-mapped cache model and a word-equals-address memory.
module tb_data_cache;
    import data_cache_pkg::*;

    localparam int LINES = 256;
    localparam int P     = 4;
    localparam int IDX_W = $clog2(LINES);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_cache_if bus();

`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    data_cache #(.LINES(LINES), .MISS_PENALTY(P)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef DATA_CACHE_STATS_EN
        .hit_count  (hit_count),
        .miss_count (miss_count),
`endif
        .bus        (bus)
    );

    // Memory model: word i holds value i.
    always_comb begin
        bus.mem_line = {32'(bus.mem_addr), 32'(bus.mem_addr) + 32'd1,
                        32'(bus.mem_addr) + 32'd2, 32'(bus.mem_addr) + 32'd3};
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          m_valid [LINES];
    int unsigned m_tag   [LINES];
    int          m_hits;
    int          m_misses;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic model_access(input int unsigned a, output bit hit);
        int unsigned idx;
        int unsigned tg;
        idx = (a >> 2) % LINES;
        tg  = a >> (2 + IDX_W);
        hit = m_valid[idx] && (m_tag[idx] == tg);
        if (hit) begin
            m_hits++;
        end else begin
            m_misses++;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_hit", 32'(bus.resp_hit), 32'd0);
        check("rst_rdata", bus.cpu_rdata, 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(bus.cpu_ready), 32'd1);
        model_clear();
    endtask

    task automatic do_read(input logic [14:0] a);
        bit hit;
        int lat;
        int exp_lat;
        logic [31:0] exp_word;
        model_access(int'(a), hit);
        exp_q.push_back(32'(a));
        exp_lat = hit ? 1 : P + 2;
        @(negedge clk);
        check("ready_idle", 32'(bus.cpu_ready), 32'd1);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = a;
        @(posedge clk);
        #1;
        bus.cpu_req  = 1'($urandom_range(0, 1));
        bus.cpu_addr = 15'($urandom);
        lat = 0;
        for (int e = 1; e <= 64 && lat == 0; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 1 && !hit) begin
                check("fill_mem_addr", 32'(bus.mem_addr), 32'(a & 15'h7ffc));
                check("busy_ready", 32'(bus.cpu_ready), 32'd0);
            end
            if (bus.resp_valid) begin
                lat = e;
                bus.cpu_req = 1'b0;
            end else begin
                bus.cpu_req  = (e < exp_lat) ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.cpu_addr = 15'($urandom);
            end
        end
        bus.cpu_req = 1'b0;
        exp_word = exp_q.pop_front();
        if (lat == 0) begin
            check("resp_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", 32'(lat), 32'(exp_lat));
            check("rdata", bus.cpu_rdata, exp_word);
            check("resp_hit", 32'(bus.resp_hit), 32'(hit));
            @(negedge clk);
            check("pulse_width", 32'(bus.resp_valid), 32'd0);
            check("rdata_hold", bus.cpu_rdata, exp_word);
        end
    endtask

    task automatic mid_fill_reset(input logic [14:0] a);
        bit hit;
        bit seen;
        model_access(int'(a), hit);
        check("midfill_is_miss", 32'(hit), 32'd0);
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = a;
        @(posedge clk);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midfill_mem_addr", 32'(bus.mem_addr), 32'(a & 15'h7ffc));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midfill_rst_rdata", bus.cpu_rdata, 32'd0);
        check("midfill_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        rst = 1'b1;
        model_clear();
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.resp_valid) seen = 1'b1;
        end
        check("midfill_no_resp", 32'(seen), 32'd0);
        check("midfill_ready", 32'(bus.cpu_ready), 32'd1);
    endtask

    task automatic back_to_back();
        bit h1;
        bit h2;
        model_access(32'h11, h1);
        model_access(32'h12, h2);
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 15'h0011;
        @(posedge clk);
        @(negedge clk);
        bus.cpu_addr = 15'h0012;
        @(posedge clk);
        @(negedge clk);
        check("b2b_valid1", 32'(bus.resp_valid), 32'd1);
        check("b2b_rdata1", bus.cpu_rdata, 32'h11);
        check("b2b_hit1", 32'(bus.resp_hit), 32'(h1));
        check("b2b_ready1", 32'(bus.cpu_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        check("b2b_gap", 32'(bus.resp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("b2b_valid2", 32'(bus.resp_valid), 32'd1);
        check("b2b_rdata2", bus.cpu_rdata, 32'h12);
        check("b2b_hit2", 32'(bus.resp_hit), 32'(h2));
    endtask

    task automatic check_stats();
`ifdef DATA_CACHE_STATS_EN
        check("hit_count", hit_count, 32'(m_hits));
        check("miss_count", miss_count, 32'(m_misses));
`endif
    endtask

    initial begin
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = '0;
        model_clear();
        do_reset();

        do_read(15'h0010);
        do_read(15'h0013);
        do_read(15'h0410);
        do_read(15'h0010);
        mid_fill_reset(15'h0413);
        do_read(15'h0413);
        check_stats();

        do_read(15'h0010);
        back_to_back();

        for (int i = 0; i < 40; i++) begin
            logic [14:0] a;
            if ($urandom_range(0, 7) == 0) begin
                a = 15'($urandom);
            end else begin
                a = 15'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 2)
                        | $urandom_range(0, 3));
            end
            do_read(a);
        end
        check_stats();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
